// File: rtl/code_entry_sequencer.sv
// Collects three switch digits on debounced ENTER presses, then replays them on x on three back-to-back cycles.
// Optional feature macro: ENTRY_TIMEOUT_EN (discard a partial entry after TIMEOUT_CYCLES idle cycles).
module code_entry_sequencer #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         TIMEOUT_CYCLES  = 1000000,
  parameter logic [2:0] IDLE_CODE       = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       enter_btn,
  output logic [2:0] x,
  output logic       burst_active,
  output logic [1:0] digit_count,
  output logic       timeout_flag
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {COLLECT, BURST} state_t;

  logic [2:0]      sw_meta_q, sw_sync_q;
  logic            btn_meta_q, btn_sync_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            db_prev_q;
  logic            press;
  logic            expire;

  state_t          state_q, state_d;
  logic [1:0]      digit_count_q, digit_count_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0][2:0] dig_buf_q, dig_buf_d;
  logic [2:0]      x_q, x_d;
  logic            burst_active_q, burst_active_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q  <= 3'b000;
      sw_sync_q  <= 3'b000;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= enter_btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Level only follows the synced button after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
    end
  end

  assign press = db_level_q & ~db_prev_q;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_flag_q, timeout_flag_d;

  // A press in the expiry cycle suppresses the timeout and restarts the count.
  always_comb begin
    idle_cnt_d     = '0;
    expire         = 1'b0;
    if (state_q == COLLECT && !press && digit_count_q != 2'd0) begin
      if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        expire = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + TO_W'(1);
      end
    end
    timeout_flag_d = expire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      idle_cnt_q     <= idle_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign expire       = 1'b0;
  // Reference kept so both builds accept the same parameter set.
  assign timeout_flag = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // BURST holds for idx 0..3: three replay cycles plus one idle cycle that still drops presses.
  always_comb begin
    state_d        = state_q;
    digit_count_d  = digit_count_q;
    idx_d          = idx_q;
    dig_buf_d      = dig_buf_q;
    x_d            = IDLE_CODE;
    burst_active_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (press) begin
          dig_buf_d[digit_count_q] = sw_sync_q;
          if (digit_count_q == 2'd2) begin
            digit_count_d = 2'd0;
            idx_d         = 2'd0;
            state_d       = BURST;
          end else begin
            digit_count_d = digit_count_q + 2'd1;
          end
        end else if (expire) begin
          digit_count_d = 2'd0;
        end
      end
      BURST: begin
        if (idx_q == 2'd3) begin
          state_d = COLLECT;
        end else begin
          x_d            = dig_buf_q[idx_q];
          burst_active_d = 1'b1;
          idx_d          = idx_q + 2'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= COLLECT;
      digit_count_q  <= 2'd0;
      idx_q          <= 2'd0;
      dig_buf_q      <= '0;
      x_q            <= IDLE_CODE;
      burst_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      digit_count_q  <= digit_count_d;
      idx_q          <= idx_d;
      dig_buf_q      <= dig_buf_d;
      x_q            <= x_d;
      burst_active_q <= burst_active_d;
    end
  end

  assign x            = x_q;
  assign burst_active = burst_active_q;
  assign digit_count  = digit_count_q;
endmodule

// File: tb/tb_code_entry_sequencer.sv
// Bench for code_entry_sequencer: directed scenarios plus random button/switch traffic,
// checked every cycle against an event-level model of synchroniser, debounce, capture and replay.
module tb_code_entry_sequencer;
  localparam int DB = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sw = 3'b000;
  logic       enter_btn = 1'b0;
  logic [2:0] x;
  logic       burst_active;
  logic [1:0] digit_count;
  logic       timeout_flag;

  int n_tests = 0;
  int n_fail  = 0;

  code_entry_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .IDLE_CODE      (3'b000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .enter_btn   (enter_btn),
    .x           (x),
    .burst_active(burst_active),
    .digit_count (digit_count),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  int         m_e, m_busy_until, m_burst_start, m_last_press, m_count;
  logic [2:0] m_buf [3];
  logic [2:0] m_snap[3];
  logic       m_level, m_rise_prev;
  logic       d1_btn, d2_btn;
  logic [2:0] d1_sw, d2_sw;
  bit         m_win[$];
  logic [2:0] exp_x;
  logic       exp_ba, exp_tf;
  logic [1:0] exp_dc;
  bit         model_valid = 0;

  task automatic model_reset();
    m_e = 0; m_busy_until = -1; m_burst_start = -100; m_last_press = 0; m_count = 0;
    for (int i = 0; i < 3; i++) begin m_buf[i] = 3'b000; m_snap[i] = 3'b000; end
    m_level = 0; m_rise_prev = 0; d1_btn = 0; d2_btn = 0; d1_sw = 0; d2_sw = 0;
    m_win.delete();
    exp_x = 3'b000; exp_ba = 0; exp_tf = 0; exp_dc = 2'd0;
    model_valid = 1;
  endtask

  task automatic model_step();
    logic       s_btn, press, flip;
    logic [2:0] s_sw;
    m_e++;
    // inputs as seen after the two-stage synchroniser
    s_btn = d2_btn; s_sw = d2_sw;
    d2_btn = d1_btn; d2_sw = d1_sw;
    d1_btn = enter_btn; d1_sw = sw;
    press = m_rise_prev;
    // level flips when the last DB synced samples all disagree with it
    m_win.push_back(s_btn);
    if (m_win.size() > DB) void'(m_win.pop_front());
    flip = (m_win.size() == DB);
    foreach (m_win[i]) if (m_win[i] == m_level) flip = 0;
    m_rise_prev = flip && !m_level;
    if (flip) begin m_level = !m_level; m_win.delete(); end
    exp_tf = 0;
    if (press && m_e > m_busy_until) begin
      m_buf[m_count] = s_sw;
      m_count++;
      m_last_press = m_e;
      if (m_count == 3) begin
        m_count = 0;
        m_snap = m_buf;
        m_burst_start = m_e;
        m_busy_until = m_e + 4;
      end
    end
`ifdef ENTRY_TIMEOUT_EN
    else if (m_count > 0 && (m_e - m_last_press) == TO) begin
      m_count = 0;
      exp_tf = 1;
    end
`endif
    exp_ba = (m_e >= m_burst_start + 1) && (m_e <= m_burst_start + 3);
    exp_x  = exp_ba ? m_snap[m_e - m_burst_start - 1] : 3'b000;
    exp_dc = 2'(m_count);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare and burst logging ----------------
  int         tb_cyc = 0;
  logic [2:0] log_x[$];
  int         log_cyc[$];
  int         tf_count = 0;

  initial begin
    forever begin
      @(negedge clk);
      tb_cyc++;
      if (!reset && model_valid) begin
        check("x", x, exp_x);
        check("burst_active", burst_active, exp_ba);
        check("digit_count", digit_count, exp_dc);
        check("timeout_flag", timeout_flag, exp_tf);
        if (burst_active === 1'b1) begin log_x.push_back(x); log_cyc.push_back(tb_cyc); end
        if (timeout_flag === 1'b1) tf_count++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    enter_btn = 0;
    reset = 1;
    tick(3);
    reset = 0;
    tick(1);
  endtask

  task automatic press_digit(input logic [2:0] v);
    sw = v;
    tick(3);
    enter_btn = 1;
    tick(DB + 6);
    enter_btn = 0;
    tick(DB + 6);
  endtask

  task automatic check_burst(input string name, input logic [2:0] v0, input logic [2:0] v1,
                             input logic [2:0] v2);
    check({name, "_len"}, log_x.size(), 3);
    if (log_x.size() == 3) begin
      check({name, "_d0"}, log_x[0], v0);
      check({name, "_d1"}, log_x[1], v1);
      check({name, "_d2"}, log_x[2], v2);
      check({name, "_consec"}, log_cyc[2] - log_cyc[0], 2);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    @(negedge clk);
    check("rst_x", x, 3'b000);
    check("rst_burst_active", burst_active, 0);
    check("rst_digit_count", digit_count, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    do_reset();

    // 1: clean presses
    log_x.delete(); log_cyc.delete();
    press_digit(3'b011); press_digit(3'b111); press_digit(3'b101);
    tick(5);
    check_burst("t1_burst", 3'b011, 3'b111, 3'b101);
    check("t1_x_after", x, 3'b000);
    $display("[TB] test1 clean presses: burst of %0d digits", log_x.size());

    // 2: bouncing button
    do_reset();
    sw = 3'b110;
    tick(3);
    for (int i = 0; i < 5; i++) begin enter_btn = (i % 2 == 0); tick(2); end
    enter_btn = 1; tick(12);
    enter_btn = 0; tick(10);
    check("t2_digit_count", digit_count, 1);
    $display("[TB] test2 bouncing button: digit_count=%0d", digit_count);

    // 3: long hold
    do_reset();
    sw = 3'b010;
    tick(3);
    enter_btn = 1; tick(200);
    check("t3_digit_count", digit_count, 1);
    enter_btn = 0; tick(10);
    $display("[TB] test3 long hold: digit_count=%0d", digit_count);

    // 4: button still held through the burst
    do_reset();
    log_x.delete(); log_cyc.delete();
    press_digit(3'b001); press_digit(3'b000);
    sw = 3'b100; tick(3);
    enter_btn = 1; tick(30);
    enter_btn = 0; tick(10);
    check_burst("t4_burst", 3'b001, 3'b000, 3'b100);
    check("t4_digit_count", digit_count, 0);
    check("t4_x", x, 3'b000);
    $display("[TB] test4 hold across burst: digit_count=%0d", digit_count);

    // 5: partial entry then idle
    do_reset();
    press_digit(3'b101); press_digit(3'b011);
    tf_count = 0;
    tick(TO + 10);
`ifdef ENTRY_TIMEOUT_EN
    check("t5_tf_pulses", tf_count, 1);
    check("t5_digit_count", digit_count, 0);
    log_x.delete(); log_cyc.delete();
    press_digit(3'b110); press_digit(3'b001); press_digit(3'b111);
    tick(5);
    check_burst("t5_burst", 3'b110, 3'b001, 3'b111);
`else
    check("t5_tf_pulses", tf_count, 0);
    check("t5_digit_count", digit_count, 2);
`endif
    $display("[TB] test5 idle partial entry: timeout pulses=%0d", tf_count);

    // 6: reset during burst
    do_reset();
    press_digit(3'b001); press_digit(3'b010);
    sw = 3'b100; tick(3);
    enter_btn = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (burst_active === 1'b1) seen = 1;
    end
    check("t6_burst_seen", seen, 1);
    @(negedge clk);
    check("t6_x_buf1", x, 3'b010);
    #2 reset = 1;
    #1;
    check("t6_async_x", x, 3'b000);
    check("t6_async_burst_active", burst_active, 0);
    enter_btn = 0;
    tick(2);
    reset = 0;
    tick(2);
    check("t6_digit_count", digit_count, 0);
    check("t6_x", x, 3'b000);
    $display("[TB] test6 reset mid-burst: x=%0d burst_active=%0d", x, burst_active);

    // random traffic, checked by the per-cycle compare
    do_reset();
    for (int i = 0; i < 250; i++) begin
      sw = 3'($urandom);
      enter_btn = 1'($urandom);
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 19) == 0) tick(TO + 5);
    end
    tick(20);
    $display("[TB] random traffic done at cycle %0d", tb_cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
